// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider.
// Holds the FSM state encoding and the widest supported operand.
package div_pkg;

  localparam int DIV_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/cla_subtractor.sv
// N-bit a-b built as a+~b+1 on a carry-lookahead network.
// borrow_n is the carry out: 1 means a >= b.
module cla_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_n
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g    = a & ~b;
  assign p    = a ^ ~b;
  assign c[0] = 1'b1;

  // Each carry is a flat sum of generate terms and the carry-in.
  for (genvar i = 0; i < N; i++) begin : g_cla
    logic cy;
    logic pp;

    always_comb begin
      cy = 1'b0;
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        cy = cy | (pp & g[j]);
        pp = pp & p[j];
      end
      cy = cy | pp;
    end

    assign c[i+1] = cy;
  end

  assign diff     = p ^ c[N-1:0];
  assign borrow_n = c[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Operands and results move over valid/ready handshakes.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t state;
  state_t next;

  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_b;
  logic [WIDTH:0]   diff;
  logic             borrow_n;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    count;
  logic             last;
  logic             unused_rem_msb;

  assign trial_a        = {rem[WIDTH-1:0], q[WIDTH-1]};
  assign trial_b        = {1'b0, dsr};
  assign last           = (count == CW'(WIDTH - 1));
  assign unused_rem_msb = rem[WIDTH];

  cla_subtractor #(
    .N(WIDTH + 1)
  ) u_sub (
    .a       (trial_a),
    .b       (trial_b),
    .diff    (diff),
    .borrow_n(borrow_n)
  );

  // Restore by keeping the shifted value when the trial borrows.
  always_comb begin
    rem_next = borrow_n ? diff : trial_a;
    q_next   = {q[WIDTH-2:0], borrow_n};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next      = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last) begin
          next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem         <= '0;
      q           <= '0;
      dsr         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            dsr   <= divisor;
            count <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              rem <= '0;
              q   <= dividend;
            end
          end
        end
        CALC: begin
          rem   <= rem_next;
          q     <= q_next;
          count <= count + 1'b1;
          if (last) begin
            quotient    <= q_next;
            remainder   <= rem_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench: a 4-bit instance for directed cases,
// an 8-bit instance for randomized traffic.
module tb_seq_restoring_divider;

  typedef struct {
    logic [7:0] n;
    logic [7:0] d;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         acc;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       iv   [2];
  logic       ir   [2];
  logic       ov   [2];
  logic       ordy [2];
  logic       dz   [2];
  logic [7:0] opn  [2];
  logic [7:0] opd  [2];
  logic [7:0] quo  [2];
  logic [7:0] rmd  [2];
  logic [3:0] q4;
  logic [3:0] r4;
  logic [7:0] q8;
  logic [7:0] r8;

  assign quo[0] = {4'h0, q4};
  assign rmd[0] = {4'h0, r4};
  assign quo[1] = q8;
  assign rmd[1] = r8;

  seq_restoring_divider #(.WIDTH(4)) u4 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (iv[0]),
    .in_ready   (ir[0]),
    .dividend   (opn[0][3:0]),
    .divisor    (opd[0][3:0]),
    .out_valid  (ov[0]),
    .out_ready  (ordy[0]),
    .quotient   (q4),
    .remainder  (r4),
    .div_by_zero(dz[0])
  );

  seq_restoring_divider #(.WIDTH(8)) u8 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (iv[1]),
    .in_ready   (ir[1]),
    .dividend   (opn[1]),
    .divisor    (opd[1]),
    .out_valid  (ov[1]),
    .out_ready  (ordy[1]),
    .quotient   (q8),
    .remainder  (r8),
    .div_by_zero(dz[1])
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  bit         prev  [2];
  bit         hold  [2];
  bit         aft   [2];
  int         vcyc  [2];
  logic [7:0] hq    [2];
  logic [7:0] hr    [2];
  logic       hd    [2];
  bit         rnd = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int k);
    exp_t e;
    if (rst) begin
      prev[k] = 1'b0;
      hold[k] = 1'b0;
      aft[k]  = 1'b0;
      return;
    end
    if (aft[k]) begin
      chk("post_hs_out_valid", ov[k], 0);
      chk("post_hs_in_ready", ir[k], 1);
      aft[k] = 1'b0;
    end
    if (ov[k]) begin
      if (!prev[k]) begin
        vcyc[k] = cyc;
      end else if (hold[k]) begin
        chk("hold_quotient", quo[k], hq[k]);
        chk("hold_remainder", rmd[k], hr[k]);
        chk("hold_dbz", dz[k], hd[k]);
      end
      if (ordy[k]) begin
        hold[k] = 1'b0;
        aft[k]  = 1'b1;
        if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
          chk("quotient", quo[k], e.q);
          chk("remainder", rmd[k], e.r);
          chk("div_by_zero", dz[k], e.dbz);
          chk("latency", vcyc[k] - e.acc, e.lat);
          if (e.d != 0) begin
            chk("invariant", int'(quo[k]) * int'(e.d) + int'(rmd[k]), int'(e.n));
            chk("rem_lt_div", rmd[k] < e.d, 1);
          end
        end
      end else begin
        hold[k] = 1'b1;
        hq[k]   = quo[k];
        hr[k]   = rmd[k];
        hd[k]   = dz[k];
      end
    end
    prev[k] = ov[k];
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) mon(k);
  end

  always @(posedge clk) begin
    #1;
    if (rnd) ordy[1] = ($urandom_range(0, 3) != 0);
  end

  task automatic issue(input int k, input logic [7:0] n, input logic [7:0] d, input bit push);
    exp_t       e;
    int         t;
    int         w;
    logic [7:0] mask;
    w    = (k == 0) ? 4 : 8;
    mask = (k == 0) ? 8'h0F : 8'hFF;
    @(posedge clk);
    #1;
    iv[k]  = 1'b1;
    opn[k] = n & mask;
    opd[k] = d & mask;
    t = 0;
    forever begin
      @(negedge clk);
      if (ir[k]) break;
      t++;
      if (t > 200) begin
        chk("accept_timeout", 0, 1);
        iv[k] = 1'b0;
        return;
      end
    end
    e.n   = n & mask;
    e.d   = d & mask;
    e.dbz = (e.d == 0);
    e.q   = e.dbz ? mask : e.n / e.d;
    e.r   = e.dbz ? e.n : e.n % e.d;
    e.lat = e.dbz ? 0 : w;
    @(posedge clk);
    #1;
    e.acc = cyc;
    if (push) begin
      if (k == 0) sb0.push_back(e);
      else sb1.push_back(e);
    end
    iv[k]  = 1'b0;
    opn[k] = 8'($urandom);
    opd[k] = 8'($urandom);
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (t > 500) begin
        chk("drain_timeout", 0, 1);
        return;
      end
    end while ((k == 0 ? sb0.size() : sb1.size()) != 0 || !ir[k]);
  endtask

  logic [7:0] tn [4] = '{8'd15, 8'd2, 8'd0, 8'd9};
  logic [7:0] td [4] = '{8'd1, 8'd9, 8'd5, 8'd9};

  initial begin
    int t;
    logic [7:0] n;
    logic [7:0] d;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b1;
      opn[k]  = '0;
      opd[k]  = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", ir[k], 1);
      chk("rst_out_valid", ov[k], 0);
      chk("rst_quotient", quo[k], 0);
      chk("rst_remainder", rmd[k], 0);
      chk("rst_dbz", dz[k], 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    issue(0, 8'd13, 8'd3, 1'b1);
    wait_idle(0);
    for (int i = 0; i < 4; i++) begin
      issue(0, tn[i], td[i], 1'b1);
      wait_idle(0);
    end
    issue(0, 8'd7, 8'd0, 1'b1);
    wait_idle(0);

    @(posedge clk);
    #1 ordy[0] = 1'b0;
    issue(0, 8'd14, 8'd4, 1'b1);
    t = 0;
    while (!ov[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_seen", ov[0], 1);
    repeat (3) @(posedge clk);
    #1 ordy[0] = 1'b1;
    wait_idle(0);

    issue(0, 8'd11, 8'd3, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", ir[0], 1);
    chk("abort_out_valid", ov[0], 0);
    chk("abort_quotient", quo[0], 0);
    repeat (10) @(posedge clk);
    issue(0, 8'd6, 8'd2, 1'b1);
    wait_idle(0);

    rnd = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      n = 8'($urandom);
      d = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      issue(1, n, d, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle(1);
    repeat (4) @(posedge clk);
    chk("sb0_empty", sb0.size(), 0);
    chk("sb1_empty", sb1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
